// File: rtl/load_store_unit.sv
// Load/store stage: turns ALU address + rs2 data into one valid/ready bus access,
// stalling the core until the access completes, faults or times out.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [63:0] ALU_result,
  input  logic [63:0] read_data_2,
  output logic        stall,
  output logic [63:0] load_data,
  output logic        misaligned,
  output logic        bus_error,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [63:0] bus_rdata
);

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STRB_W = 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        off_q;
  logic [2:0]        f3_q;

  logic              op_c;
  logic              illegal_c;
  logic              unaligned_c;
  logic              fault_c;
  logic              handshake_c;
  logic              timeout_c;
  logic              start_c;
  logic [STRB_W-1:0] strb_base_c;
  logic [STRB_W-1:0] strb_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   shifted_c;
  logic [XLEN-1:0]   load_ext_c;
  logic [XLEN-1:0]   load_data_d;
  logic              misaligned_d;
  logic              bus_error_d;

  assign op_c  = mem_read | mem_write;
  assign stall = op_c & (state != DONE);

  // Fault screening of the presented op (stores win over loads)
  always_comb begin
    illegal_c   = mem_write ? funct3[2] : (funct3 == 3'b111);
    unaligned_c = 1'b0;
    case (funct3[1:0])
      2'b01:   unaligned_c = ALU_result[0];
      2'b10:   unaligned_c = |ALU_result[1:0];
      2'b11:   unaligned_c = |ALU_result[2:0];
      default: unaligned_c = 1'b0;
    endcase
  end
  assign fault_c = illegal_c | unaligned_c;

  // Store lane placement
  always_comb begin
    case (funct3[1:0])
      2'b00:   strb_base_c = 8'h01;
      2'b01:   strb_base_c = 8'h03;
      2'b10:   strb_base_c = 8'h0F;
      default: strb_base_c = 8'hFF;
    endcase
  end
  assign strb_c  = strb_base_c << ALU_result[2:0];
  assign wdata_c = read_data_2 << {ALU_result[2:0], 3'b000};

  // Load lane extraction from the latched offset and size
  assign shifted_c = bus_rdata >> {off_q, 3'b000};
  always_comb begin
    case (f3_q)
      3'b000:  load_ext_c = {{56{shifted_c[7]}},  shifted_c[7:0]};
      3'b001:  load_ext_c = {{48{shifted_c[15]}}, shifted_c[15:0]};
      3'b010:  load_ext_c = {{32{shifted_c[31]}}, shifted_c[31:0]};
      3'b011:  load_ext_c = shifted_c;
      3'b100:  load_ext_c = {56'b0, shifted_c[7:0]};
      3'b101:  load_ext_c = {48'b0, shifted_c[15:0]};
      3'b110:  load_ext_c = {32'b0, shifted_c[31:0]};
      default: load_ext_c = '0;
    endcase
  end

  assign handshake_c = (state == REQ) & bus_req_valid & bus_req_ready;
  assign timeout_c   = ((state == REQ) | (state == WAIT)) & (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state; a late response still wins over the timeout in WAIT
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (op_c) state_next = fault_c ? DONE : REQ;
      REQ: begin
        if (timeout_c)        state_next = DONE;
        else if (handshake_c) state_next = WAIT;
      end
      WAIT: if (bus_rsp_valid || timeout_c) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result values captured on entry to DONE; held otherwise
  always_comb begin
    load_data_d  = load_data;
    misaligned_d = misaligned;
    bus_error_d  = bus_error;
    start_c      = 1'b0;
    case (state)
      IDLE: begin
        if (op_c) begin
          if (fault_c) begin
            load_data_d  = '0;
            misaligned_d = 1'b1;
            bus_error_d  = 1'b0;
          end else begin
            start_c = 1'b1;
          end
        end
      end
      REQ: begin
        if (timeout_c) begin
          load_data_d  = '0;
          misaligned_d = 1'b0;
          bus_error_d  = 1'b1;
        end
      end
      WAIT: begin
        if (bus_rsp_valid) begin
          load_data_d  = bus_req_we ? '0 : load_ext_c;
          misaligned_d = 1'b0;
          bus_error_d  = 1'b0;
        end else if (timeout_c) begin
          load_data_d  = '0;
          misaligned_d = 1'b0;
          bus_error_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data     <= '0;
      misaligned    <= 1'b0;
      bus_error     <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_req_we    <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_wstrb     <= '0;
      off_q         <= '0;
      f3_q          <= '0;
      cnt           <= '0;
    end else begin
      load_data     <= load_data_d;
      misaligned    <= misaligned_d;
      bus_error     <= bus_error_d;
      bus_req_valid <= (state_next == REQ);
      if (start_c) begin
        bus_req_we <= mem_write;
        bus_addr   <= {ALU_result[63:3], 3'b000};
        bus_wdata  <= mem_write ? wdata_c : '0;
        bus_wstrb  <= mem_write ? strb_c : '0;
        off_q      <= ALU_result[2:0];
        f3_q       <= funct3;
        cnt        <= '0;
      end else if ((state == REQ) || (state == WAIT)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-level reference model.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int unsigned TMO = 8;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [63:0] ALU_result;
  logic [63:0] read_data_2;
  logic        stall;
  logic [63:0] load_data;
  logic        misaligned;
  logic        bus_error;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [63:0] bus_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .ALU_result(ALU_result), .read_data_2(read_data_2),
    .stall(stall), .load_data(load_data), .misaligned(misaligned),
    .bus_error(bus_error), .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; bit chk_data; bit mis; bit err; } res_t;
  typedef struct { bit we; logic [63:0] addr; logic [63:0] wdata; logic [7:0] strb; } req_t;
  typedef struct { int rdy; int rsp; logic [63:0] rdata; bit hang; } bus_t;

  res_t res_q[$];
  req_t req_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: copy the addressed bytes, then extend
  function automatic logic [63:0] model_load(logic [2:0] f3, logic [63:0] addr, logic [63:0] rdata);
    int n = 1 << f3[1:0];
    int off = int'(addr[2:0]);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic bit model_fault(bit wr, logic [2:0] f3, logic [63:0] addr);
    int n = 1 << f3[1:0];
    if (wr ? f3[2] : (f3 == 3'b111)) return 1'b1;
    return (int'(addr[2:0]) % n) != 0;
  endfunction

  task automatic finish_now();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  // Issue one op, push expectations, wait for release and check stall/valid counts
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] rdata, input int rdy,
                       input int rsp, input bit hang, input string tag);
    int n = 1 << f3[1:0];
    int off = int'(addr[2:0]);
    int stall_exp, valid_exp, nst, nv;
    bit done;
    logic [15:0] strb16;
    res_t r;
    req_t q;
    bus_t b;
    if (model_fault(wr, f3, addr)) begin
      stall_exp = 1; valid_exp = 0;
      r = '{64'd0, 1'b1, 1'b1, 1'b0};
    end else if (hang) begin
      stall_exp = 1 + TMO; valid_exp = TMO;
      r = '{64'd0, 1'b1, 1'b0, 1'b1};
      b = '{0, 0, 64'd0, 1'b1};
      bus_q.push_back(b);
    end else begin
      stall_exp = 3 + rdy + rsp; valid_exp = rdy + 1;
      strb16 = 16'((1 << n) - 1) << off;
      q = '{wr, addr & ~64'd7, wd << (8*off), wr ? strb16[7:0] : 8'h00};
      req_q.push_back(q);
      r = '{wr ? 64'd0 : model_load(f3, addr, rdata), !wr, 1'b0, 1'b0};
      b = '{rdy, rsp, rdata, 1'b0};
      bus_q.push_back(b);
    end
    res_q.push_back(r);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; ALU_result = addr; read_data_2 = wd;
    nst = 0; nv = 0; done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus_req_valid) nv++;
      if (!stall) begin done = 1; break; end
      nst++;
    end
    if (!done) begin
      checks++;
      $display("FAIL %s: stall never released within 40 cycles", tag);
      finish_now();
    end
    check64({tag, " stall_cycles"}, 64'(nst), 64'(stall_exp));
    check64({tag, " valid_cycles"}, 64'(nv), 64'(valid_exp));
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Bus responder: ready after rdy cycles, response rsp cycles after acceptance
  initial begin
    bus_t b;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus_req_valid && bus_q.size() > 0) begin
        b = bus_q.pop_front();
        if (b.hang) begin
          for (int k = 0; k < 64 && bus_req_valid; k++) begin @(posedge clk); #1; end
        end else begin
          repeat (b.rdy) begin @(posedge clk); #1; end
          bus_req_ready = 1'b1;
          @(posedge clk); #1;
          bus_req_ready = 1'b0;
          repeat (b.rsp) begin @(posedge clk); #1; end
          bus_rsp_valid = 1'b1; bus_rdata = b.rdata;
          @(posedge clk); #1;
          bus_rsp_valid = 1'b0; bus_rdata = $urandom();
        end
      end
    end
  end

  // Request monitor
  always @(negedge clk) begin
    req_t q;
    if (rst_n && bus_req_valid && bus_req_ready) begin
      if (req_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_request: got addr %h expected none", bus_addr);
      end else begin
        q = req_q.pop_front();
        check64("req_we", 64'(bus_req_we), 64'(q.we));
        check64("req_addr", bus_addr, q.addr);
        check64("req_wstrb", 64'(bus_wstrb), 64'(q.strb));
        if (q.we) check64("req_wdata", bus_wdata, q.wdata);
      end
    end
  end

  // Result monitor: DONE is the cycle an op is presented with stall low
  always @(negedge clk) begin
    res_t r;
    if (rst_n && (mem_read || mem_write) && !stall) begin
      if (res_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got load_data %h expected none", load_data);
      end else begin
        r = res_q.pop_front();
        check64("misaligned", 64'(misaligned), 64'(r.mis));
        check64("bus_error", 64'(bus_error), 64'(r.err));
        if (r.chk_data) check64("load_data", load_data, r.data);
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check64({tag, " load_data"}, load_data, 64'd0);
    check64({tag, " flags"}, {61'd0, misaligned, bus_error, bus_req_valid}, 64'd0);
    check64({tag, " req_fields"}, {55'd0, bus_req_we, bus_wstrb}, 64'd0);
    check64({tag, " addr_wdata"}, bus_addr | bus_wdata, 64'd0);
  endtask

  initial begin
    logic [63:0] a, d, rdv;
    bit wr, rd, hang;
    logic [2:0] f3;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
    ALU_result = '0; read_data_2 = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    check64("reset stall", 64'(stall), 64'd0);
    rst_n = 1'b1;

    do_op(1, 0, 3'b011, 64'h1000, 64'd0, 64'h1122334455667788, 0, 0, 0, "LD");
    do_op(1, 0, 3'b000, 64'h1003, 64'd0, 64'h0000000080000000, 0, 0, 0, "LB");
    do_op(1, 0, 3'b100, 64'h1003, 64'd0, 64'h0000000080000000, 0, 0, 0, "LBU");
    do_op(0, 1, 3'b001, 64'h2006, 64'hABCD, 64'd0, 0, 0, 0, "SH");
    do_op(1, 0, 3'b010, 64'h3002, 64'd0, 64'd0, 0, 0, 0, "LW_mis");
    do_op(1, 0, 3'b111, 64'h3000, 64'd0, 64'd0, 0, 0, 0, "L111");
    do_op(1, 0, 3'b011, 64'h5000, 64'd0, 64'd0, 0, 0, 1, "LD_tmo");

    // Reset during WAIT; the late response must be ignored
    bus_q.push_back('{0, 6, 64'hDEADBEEFCAFEF00D, 1'b0});
    req_q.push_back('{1'b0, 64'h4000, 64'd0, 8'h00});
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b011; ALU_result = 64'h4000;
    repeat (3) @(negedge clk);
    check64("rst_wait stall", 64'(stall), 64'd1);
    rst_n = 1'b0; mem_read = 1'b0;
    #1;
    check_zero_outputs("rst_async");
    check64("rst_async stall", 64'(stall), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_zero_outputs("rst_late_rsp");
    do_op(1, 0, 3'b011, 64'h4008, 64'd0, 64'h0123456789ABCDEF, 0, 0, 0, "LD_after_rst");

    for (int i = 0; i < 150; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = 3'($urandom_range(0, 7));
      a = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'b000;
      d = {$urandom(), $urandom()};
      rdv = {$urandom(), $urandom()};
      hang = ($urandom_range(0, 19) == 0);
      do_op(rd, wr, f3, a, d, rdv, $urandom_range(0, 2), $urandom_range(0, 2), hang, "rand");
    end

    repeat (5) @(negedge clk);
    check64("res_q drained", 64'(res_q.size()), 64'd0);
    check64("req_q drained", 64'(req_q.size()), 64'd0);
    finish_now();
  end

endmodule
